reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
- 16-entry circular reorder buffer for the Tomasulo core.
- Allocates the ROB tags that issue writes into the register status table (the 6-bit tag, with invalid = 6'b010000).
- Captures results from the common data bus (CDB) and retires them in program order.
- On commit, drives the register index and tag that the status table uses to release a pending register.

Parameters:
- DEPTH, 16, number of entries; tags 0..DEPTH-1; fixed at 16 to match the 6-bit tag encoding.
- DATA_W, 32, result data width.
- INVALID_TAG, 6'b010000, the "no producer" tag value.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous squash of all entries.
- allocValid  input  1  issue requests an entry this cycle.
- allocDestReg  input  5  destination architectural register of the issuing instruction.
- allocReady  output  1  entry available (combinational).
- allocTag  output  6  tag granted to the issuing instruction (combinational).
- cdbValid  input  1  CDB broadcast valid.
- cdbTag  input  6  producing ROB tag.
- cdbData  input  DATA_W  result value.
- readTag  input  6  operand lookup tag from the status table's q1/q2 path.
- readReady  output  1  the looked-up entry holds a finished result (combinational).
- readData  output  DATA_W  the looked-up result (combinational).
- commitValid  output  1  one-cycle retire pulse (registered).
- commitReg  output  5  retired destination register.
- commitTag  output  6  retired tag; the status table clears status[commitReg] only if it still equals commitTag.
- commitData  output  DATA_W  retired value.
- count  output  5  occupied entries, 0..16 (registered).

Behaviour:
- State:
  - Per entry: busy, done, destReg[4:0], data[DATA_W-1:0].
  - head[3:0] and tail[3:0], each wrapping 15->0.
  - count[4:0].
- Reset (rst=1 at posedge; has priority over everything):
  - All busy=0 and done=0; head=tail=0; count=0.
  - commitValid=0, commitReg=0, commitTag=INVALID_TAG, commitData=0.
  - After reset: allocReady=1, allocTag=0, readReady=0, readData=0.
- Combinational outputs:
  - allocReady = (count != 16).
  - allocTag = {2'b00, tail} when allocReady=1, else INVALID_TAG.
  - readReady = (readTag < 16) && busy[readTag] && done[readTag].
  - readData = data[readTag] when readReady=1, else 0.
- Allocate (allocValid && allocReady at posedge):
  - entry[tail]: busy=1, done=0, destReg=allocDestReg.
  - tail increments.
  - allocValid while full is ignored; no state change.
- CDB capture (cdbValid && cdbTag<16 && busy[cdbTag]):
  - done=1, data=cdbData.
  - Tags >= 16 and tags of non-busy entries are silently ignored.
  - A second write to an already-done entry overwrites data.
- Commit (busy[head] && done[head] at posedge):
  - Next cycle: commitValid=1, commitReg=destReg[head], commitTag={2'b00,head}, commitData=data[head].
  - Entry is freed (busy=0, done=0); head increments.
  - At most one commit per cycle.
  - When there is no commit, commitValid=0 and the other commit outputs hold their previous values.
- Commit latency:
  - A CDB write to the head entry at edge N commits at edge N+1; commitValid is high in cycle N+1..N+2.
  - A CDB write never commits in the same edge.
- Count update: count_next = count + alloc_fire - commit_fire.
- Simultaneous events:
  - Allocate and commit in the same cycle: count is unchanged.
  - When full, allocReady=0 even if a commit fires that cycle; the freed slot is usable the following cycle.
  - CDB write to the entry being allocated in the same cycle is impossible (not busy yet) and is ignored.
- Flush (flush=1, rst=0):
  - Same state effect as reset, except commitReg, commitTag and commitData hold their values.
  - commitValid=0 that cycle.
  - Overrides alloc, CDB and commit in the same cycle.
- Wrap-around: after 16 allocations and 16 commits, head=tail=0 again; tags restart at 0.

Test Plan:
- Reset then 3 allocs (regs 5,6,7) -> allocTag 0,1,2 in turn; count=3; readTag=1 gives readReady=0.
- CDB tag 1 data 0xAA, then tag 0 data 0x55 -> tag1 readReady=1, readData=0xAA; commits in order: (reg5, tag0, 0x55) next edge, then (reg6, tag1, 0xAA) one cycle later; tag1 never commits first.
- Fill 16 entries -> allocReady=0, allocTag=6'b010000; extra allocValid ignored, count stays 16. CDB tag0 then alloc+commit together -> alloc still refused; succeeds the next cycle with allocTag=0.
- CDB with cdbTag=16, and CDB to a free entry -> no state change, no commit.
- 40 alloc/complete/commit cycles -> tags wrap 15->0; commit order matches alloc order; count never exceeds 16.
- Flush with 5 busy entries while head is done -> commitValid=0, count=0, allocTag=0 next cycle. Assert rst mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - 16-entry circular reorder buffer: tag allocation, CDB capture, in-order commit
module reorder_buffer #(
    parameter int          DEPTH       = 16,
    parameter int          DATA_W      = 32,
    parameter logic [5:0]  INVALID_TAG = 6'b010000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              allocValid,
    input  logic [4:0]        allocDestReg,
    output logic              allocReady,
    output logic [5:0]        allocTag,
    input  logic              cdbValid,
    input  logic [5:0]        cdbTag,
    input  logic [DATA_W-1:0] cdbData,
    input  logic [5:0]        readTag,
    output logic              readReady,
    output logic [DATA_W-1:0] readData,
    output logic              commitValid,
    output logic [4:0]        commitReg,
    output logic [5:0]        commitTag,
    output logic [DATA_W-1:0] commitData,
    output logic [4:0]        count
);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  done_q;
    logic [4:0]        dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [3:0]        head_q;
    logic [3:0]        tail_q;
    logic [4:0]        count_q;
    logic [4:0]        count_d;

    logic              commit_valid_q;
    logic [4:0]        commit_reg_q;
    logic [5:0]        commit_tag_q;
    logic [DATA_W-1:0] commit_data_q;

    logic              alloc_fire;
    logic              commit_fire;
    logic              cdb_hit;
    logic [3:0]        cdb_idx;
    logic [3:0]        read_idx;

    assign cdb_idx  = cdbTag[3:0];
    assign read_idx = readTag[3:0];

    // Tags 16..63 alias onto low entries by index, so the upper bits must gate every lookup.
    assign allocReady  = (count_q != 5'd16);
    assign allocTag    = allocReady ? {2'b00, tail_q} : INVALID_TAG;
    assign readReady   = (readTag[5:4] == 2'b00) && busy_q[read_idx] && done_q[read_idx];
    assign readData    = readReady ? data_q[read_idx] : '0;

    assign alloc_fire  = allocValid && allocReady;
    assign commit_fire = busy_q[head_q] && done_q[head_q];
    assign cdb_hit     = cdbValid && (cdbTag[5:4] == 2'b00) && busy_q[cdb_idx];
    assign count_d     = count_q + {4'd0, alloc_fire} - {4'd0, commit_fire};

    assign commitValid = commit_valid_q;
    assign commitReg   = commit_reg_q;
    assign commitTag   = commit_tag_q;
    assign commitData  = commit_data_q;
    assign count       = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
            commit_reg_q   <= '0;
            commit_tag_q   <= INVALID_TAG;
            commit_data_q  <= '0;
        end else if (flush) begin
            busy_q         <= '0;
            done_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_valid_q <= 1'b0;
        end else begin
            commit_valid_q <= commit_fire;
            if (cdb_hit) begin
                done_q[cdb_idx] <= 1'b1;
                data_q[cdb_idx] <= cdbData;
            end
            // Commit reads pre-edge state, so a CDB write this edge only shows up next edge.
            if (commit_fire) begin
                commit_reg_q   <= dest_q[head_q];
                commit_tag_q   <= {2'b00, head_q};
                commit_data_q  <= data_q[head_q];
                busy_q[head_q] <= 1'b0;
                done_q[head_q] <= 1'b0;
                head_q         <= head_q + 4'd1;
            end
            if (alloc_fire) begin
                busy_q[tail_q] <= 1'b1;
                done_q[tail_q] <= 1'b0;
                dest_q[tail_q] <= allocDestReg;
                tail_q         <= tail_q + 4'd1;
            end
            count_q <= count_d;
        end
    end

endmodule
